// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master round-robin pipelined Wishbone arbiter with ack timeout abort
module wb_arbiter2 #(
  parameter int TIMEOUT_CYCLES  = 1024,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_m0_cyc,
  input  logic        i_m0_stb,
  input  logic        i_m0_we,
  input  logic [31:0] i_m0_addr,
  input  logic [31:0] i_m0_data,
  input  logic [3:0]  i_m0_sel,
  output logic        o_m0_stall,
  output logic        o_m0_ack,
  output logic        o_m0_err,
  output logic [31:0] o_m0_data,
  input  logic        i_m1_cyc,
  input  logic        i_m1_stb,
  input  logic        i_m1_we,
  input  logic [31:0] i_m1_addr,
  input  logic [31:0] i_m1_data,
  input  logic [3:0]  i_m1_sel,
  output logic        o_m1_stall,
  output logic        o_m1_ack,
  output logic        o_m1_err,
  output logic [31:0] o_m1_data,
  output logic        o_s_cyc,
  output logic        o_s_stb,
  output logic        o_s_we,
  output logic [31:0] o_s_addr,
  output logic [31:0] o_s_data,
  output logic [3:0]  o_s_sel,
  input  logic        i_s_stall,
  input  logic        i_s_ack,
  input  logic [31:0] i_s_data
);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic [OW-1:0] out_q, out_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          own0, own1, own, full, abort, acc;
  logic          m_cyc, m_stb, m_we;
  logic [31:0]   m_addr, m_data;
  logic [3:0]    m_sel;
  assign own0   = state_q == OWN0;
  assign own1   = state_q == OWN1;
  assign own    = own0 | own1;
  assign m_cyc  = own1 ? i_m1_cyc  : i_m0_cyc;
  assign m_stb  = own1 ? i_m1_stb  : i_m0_stb;
  assign m_we   = own1 ? i_m1_we   : i_m0_we;
  assign m_addr = own1 ? i_m1_addr : i_m0_addr;
  assign m_data = own1 ? i_m1_data : i_m0_data;
  assign m_sel  = own1 ? i_m1_sel  : i_m0_sel;
  assign full   = out_q == OW'(MAX_OUTSTANDING);
  // abort fires in the last ack-less cycle of the window unless an ack lands right then
  assign abort  = own && out_q != '0 && tmo_q == TW'(TIMEOUT_CYCLES - 1) && !i_s_ack;
  assign o_s_cyc  = own & m_cyc & ~abort;
  assign o_s_stb  = own & m_cyc & m_stb & ~full & ~abort;
  assign o_s_we   = own & m_we;
  assign o_s_addr = own ? m_addr : '0;
  assign o_s_data = own ? m_data : '0;
  assign o_s_sel  = own ? m_sel  : '0;
  assign acc      = o_s_stb & ~i_s_stall;
  assign o_m0_stall = ~own0 | i_s_stall | full | abort;
  assign o_m0_ack   = own0 & i_s_ack;
  assign o_m0_err   = own0 & abort;
  assign o_m0_data  = own0 ? i_s_data : '0;
  assign o_m1_stall = ~own1 | i_s_stall | full | abort;
  assign o_m1_ack   = own1 & i_s_ack;
  assign o_m1_err   = own1 & abort;
  assign o_m1_data  = own1 ? i_s_data : '0;
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    out_d   = out_q;
    tmo_d   = tmo_q;
    if (!own) begin
      out_d   = '0;
      tmo_d   = '0;
      state_d = (i_m0_cyc && (!i_m1_cyc || last_q)) ? OWN0 : i_m1_cyc ? OWN1 : IDLE;
    end else if (!m_cyc || abort) begin
      state_d = IDLE;
      last_d  = own1;
      out_d   = '0;
      tmo_d   = '0;
    end else begin
      out_d = out_q + OW'(acc) - OW'(i_s_ack && out_q != '0);
      tmo_d = (acc || i_s_ack || out_q == '0) ? '0 : tmo_q + 1'b1;
    end
  end
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      out_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      out_q   <= out_d;
      tmo_q   <= tmo_d;
    end
  end
endmodule

// File: tb/tb_wb_arbiter2.sv
// tb_wb_arbiter2: directed bench for wb_arbiter2; responses checked by a queue-fed monitor
module tb_wb_arbiter2;
  logic        i_clk = 1'b0, i_rst = 1'b0;
  logic        i_m0_cyc, i_m0_stb, i_m0_we, i_m1_cyc, i_m1_stb, i_m1_we;
  logic [31:0] i_m0_addr, i_m0_data, i_m1_addr, i_m1_data;
  logic [3:0]  i_m0_sel, i_m1_sel;
  logic        o_m0_stall, o_m0_ack, o_m0_err, o_m1_stall, o_m1_ack, o_m1_err;
  logic [31:0] o_m0_data, o_m1_data;
  logic        o_s_cyc, o_s_stb, o_s_we;
  logic [31:0] o_s_addr, o_s_data;
  logic [3:0]  o_s_sel;
  logic        i_s_stall, i_s_ack;
  logic [31:0] i_s_data;
  typedef struct {int m; logic err; logic [31:0] d;} exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;
  logic [31:0] addr_t[2] = '{32'h0200_0004, 32'h0200_0008};
  logic [31:0] wdat_t[2] = '{32'h0000_00FF, 32'h0000_0041};
  wb_arbiter2 #(.TIMEOUT_CYCLES(16), .MAX_OUTSTANDING(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_m0_cyc(i_m0_cyc), .i_m0_stb(i_m0_stb), .i_m0_we(i_m0_we),
    .i_m0_addr(i_m0_addr), .i_m0_data(i_m0_data), .i_m0_sel(i_m0_sel),
    .o_m0_stall(o_m0_stall), .o_m0_ack(o_m0_ack), .o_m0_err(o_m0_err), .o_m0_data(o_m0_data),
    .i_m1_cyc(i_m1_cyc), .i_m1_stb(i_m1_stb), .i_m1_we(i_m1_we),
    .i_m1_addr(i_m1_addr), .i_m1_data(i_m1_data), .i_m1_sel(i_m1_sel),
    .o_m1_stall(o_m1_stall), .o_m1_ack(o_m1_ack), .o_m1_err(o_m1_err), .o_m1_data(o_m1_data),
    .o_s_cyc(o_s_cyc), .o_s_stb(o_s_stb), .o_s_we(o_s_we),
    .o_s_addr(o_s_addr), .o_s_data(o_s_data), .o_s_sel(o_s_sel),
    .i_s_stall(i_s_stall), .i_s_ack(i_s_ack), .i_s_data(i_s_data)
  );
  always #5 i_clk = ~i_clk;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask
  task automatic drv(input int m, input logic cyc, input logic stb, input logic we,
                     input logic [31:0] a, input logic [31:0] d);
    if (m == 0) begin
      i_m0_cyc = cyc; i_m0_stb = stb; i_m0_we = we; i_m0_addr = a; i_m0_data = d; i_m0_sel = 4'hF;
    end else begin
      i_m1_cyc = cyc; i_m1_stb = stb; i_m1_we = we; i_m1_addr = a; i_m1_data = d; i_m1_sel = 4'hF;
    end
  endtask
  function automatic logic stl(input int m);
    return (m == 0) ? o_m0_stall : o_m1_stall;
  endfunction
  task automatic expect_rsp(input int m, input logic err, input logic [31:0] d);
    exp_t e;
    e.m = m; e.err = err; e.d = d;
    sb.push_back(e);
  endtask
  // monitor: every ack/err seen by a master must match the oldest queued expectation
  always @(negedge i_clk) begin
    for (int m = 0; m < 2; m++) begin
      logic a, e;
      logic [31:0] d;
      exp_t x;
      a = (m == 0) ? o_m0_ack : o_m1_ack;
      e = (m == 0) ? o_m0_err : o_m1_err;
      d = (m == 0) ? o_m0_data : o_m1_data;
      if (a || e) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected m%0d: got ack=%b err=%b expected no response", m, a, e);
        end else begin
          x = sb.pop_front();
          if (x.m != m || x.err != e || (a && e) || (!e && d !== x.d)) begin
            errors++;
            $display("FAIL rsp m%0d: got ack=%b err=%b data=%h expected m%0d err=%b data=%h",
                     m, a, e, d, x.m, x.err, x.d);
          end
        end
      end
    end
  end
  task automatic contend(input int f);
    int s;
    s = 1 - f;
    tick;
    drv(0, 1, 1, 1, addr_t[0], wdat_t[0]);
    drv(1, 1, 1, 1, addr_t[1], wdat_t[1]);
    #1 chk("ct_idle_stall0", stl(0), 1); chk("ct_idle_stall1", stl(1), 1);
    tick;
    #1 chk("ct_first_addr", o_s_addr, addr_t[f]); chk("ct_first_data", o_s_data, wdat_t[f]);
    chk("ct_first_we", o_s_we, 1); chk("ct_first_stall", stl(f), 0); chk("ct_other_stall", stl(s), 1);
    tick;
    drv(f, 1, 0, 1, addr_t[f], wdat_t[f]);
    i_s_ack = 1; i_s_data = 32'h1000_0000 + f; expect_rsp(f, 0, 32'h1000_0000 + f);
    #1 chk("ct_other_stall_ack", stl(s), 1);
    tick;
    i_s_ack = 0; drv(f, 0, 0, 0, 0, 0);
    #1 chk("ct_release_cyc", o_s_cyc, 0); chk("ct_release_stall", stl(s), 1);
    tick;
    #1 chk("ct_gap_cyc", o_s_cyc, 0); chk("ct_gap_stall", stl(s), 1);
    tick;
    #1 chk("ct_second_addr", o_s_addr, addr_t[s]); chk("ct_second_data", o_s_data, wdat_t[s]);
    chk("ct_second_stall", stl(s), 0); chk("ct_loser_stall", stl(f), 1);
    tick;
    drv(s, 1, 0, 1, addr_t[s], wdat_t[s]);
    i_s_ack = 1; i_s_data = 32'h2000_0000 + s; expect_rsp(s, 0, 32'h2000_0000 + s);
    #1 chk("ct_loser_stall_ack", stl(f), 1);
    tick;
    i_s_ack = 0; drv(s, 0, 0, 0, 0, 0);
    #1 chk("ct_loser_stall_end", stl(f), 1);
    tick;
  endtask
  initial begin
    int early;
    drv(0, 0, 0, 0, 0, 0); drv(1, 0, 0, 0, 0, 0);
    i_s_stall = 0; i_s_ack = 0; i_s_data = 0;
    repeat (2) tick;
    chk("rst_s_cyc", o_s_cyc, 0); chk("rst_m0_stall", o_m0_stall, 1);
    chk("rst_m1_stall", o_m1_stall, 1); chk("rst_s_addr", o_s_addr, 0);
    i_rst = 1;
    tick;
    // single read by m0
    drv(0, 1, 1, 0, 32'h10, 0);
    #1 chk("t1_wait_s_cyc", o_s_cyc, 0); chk("t1_wait_stall", o_m0_stall, 1);
    tick;
    #1 chk("t1_s_cyc", o_s_cyc, 1); chk("t1_s_addr", o_s_addr, 32'h10); chk("t1_stall", o_m0_stall, 0);
    tick;
    drv(0, 1, 0, 0, 32'h10, 0);
    tick;
    i_s_ack = 1; i_s_data = 32'hDEAD_BEEF; expect_rsp(0, 0, 32'hDEAD_BEEF);
    #1 chk("t1_m1_ack", o_m1_ack, 0); chk("t1_m0_data", o_m0_data, 32'hDEAD_BEEF);
    tick;
    i_s_ack = 0; i_s_data = 0; drv(0, 0, 0, 0, 0, 0);
    tick;
    #1 chk("t1_idle_s_cyc", o_s_cyc, 0);
    // m0 was last granted, so m1 wins the tie; after reset m0 wins it
    contend(1);
    i_rst = 0;
    tick;
    i_rst = 1;
    contend(0);
    // outstanding limit
    tick;
    drv(0, 1, 1, 0, 32'h400, 0);
    #1 chk("t4_idle_stall", o_m0_stall, 1);
    for (int i = 0; i < 4; i++) begin
      tick;
      i_m0_addr = 32'h400 + 4 * i;
      #1 chk("t4_accept_stall", o_m0_stall, 0); chk("t4_accept_stb", o_s_stb, 1);
    end
    tick;
    #1 chk("t4_full_stall", o_m0_stall, 1); chk("t4_full_stb", o_s_stb, 0); chk("t4_full_cyc", o_s_cyc, 1);
    drv(0, 1, 0, 0, 32'h410, 0);
    for (int i = 0; i < 4; i++) begin
      tick;
      i_s_ack = 1; i_s_data = 32'h100 + i; expect_rsp(0, 0, 32'h100 + i);
    end
    tick;
    i_s_ack = 0; drv(0, 1, 1, 0, 32'h500, 0);
    #1 chk("t4_resume_stall", o_m0_stall, 0); chk("t4_resume_stb", o_s_stb, 1);
    tick;
    #1 chk("t4_resume2_stall", o_m0_stall, 0); chk("t4_resume2_stb", o_s_stb, 1);
    tick;
    drv(0, 1, 0, 0, 32'h504, 0);
    i_s_ack = 1; i_s_data = 32'h200; expect_rsp(0, 0, 32'h200);
    tick;
    i_s_data = 32'h201; expect_rsp(0, 0, 32'h201);
    tick;
    i_s_ack = 0; drv(0, 0, 0, 0, 0, 0);
    tick;
    // timeout on m1 with m0 waiting
    tick;
    drv(1, 1, 1, 0, 32'h3000, 0);
    #1 chk("t5_idle_stall", o_m1_stall, 1);
    tick;
    #1 chk("t5_accept_stall", o_m1_stall, 0);
    tick;
    drv(1, 1, 0, 0, 32'h3000, 0); drv(0, 1, 1, 0, 32'h600, 0);
    early = 0;
    for (int k = 1; k < 16; k++) begin
      #1 if (o_m1_err) early++;
      tick;
    end
    chk("t5_no_early_err", early, 0);
    expect_rsp(1, 1, 0);
    #1 chk("t5_err", o_m1_err, 1); chk("t5_abort_cyc", o_s_cyc, 0); chk("t5_m0_stall", o_m0_stall, 1);
    tick;
    drv(1, 0, 0, 0, 0, 0);
    i_s_ack = 1; i_s_data = 32'hBAD;
    #1 chk("t5_late_ack_m0", o_m0_ack, 0); chk("t5_late_ack_m1", o_m1_ack, 0);
    tick;
    i_s_ack = 0; i_s_data = 0;
    #1 chk("t5_m0_grant", o_m0_stall, 0); chk("t5_m0_addr", o_s_addr, 32'h600);
    tick;
    drv(0, 0, 0, 0, 0, 0);
    tick;
    // reset with two outstanding in OWN1
    tick;
    drv(1, 1, 1, 0, 32'h700, 0);
    tick;
    #1 chk("t6_accept_stall", o_m1_stall, 0);
    tick;
    tick;
    drv(1, 1, 0, 0, 32'h700, 0); drv(0, 1, 1, 0, 32'h800, 0);
    #1 chk("t6_owned_cyc", o_s_cyc, 1);
    #2 i_rst = 0; i_s_ack = 1;
    #1 chk("t6_rst_cyc", o_s_cyc, 0); chk("t6_rst_m1_stall", o_m1_stall, 1);
    chk("t6_rst_m0_stall", o_m0_stall, 1); chk("t6_rst_m1_ack", o_m1_ack, 0);
    tick;
    tick;
    i_s_ack = 0; i_rst = 1;
    #1 chk("t6_idle_m0_stall", o_m0_stall, 1); chk("t6_idle_m1_stall", o_m1_stall, 1);
    tick;
    #1 chk("t6_tie_m0", o_m0_stall, 0); chk("t6_tie_m1", o_m1_stall, 1); chk("t6_tie_addr", o_s_addr, 32'h800);
    drv(0, 0, 0, 0, 0, 0); drv(1, 0, 0, 0, 0, 0);
    tick;
    tick;
    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
